// File: rtl/m84_sample_ctrl.sv
// M84 sample-playback sequencer: assembles the sample address from Z80 port
// writes, fetches the addressed byte from sample ROM and latches DAC bytes.
module m84_sample_ctrl #(
    parameter int                ROM_AW   = 24,
    parameter logic [ROM_AW-1:0] ROM_BASE = ROM_AW'(24'h000000)
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic [15:0]       sample_addr,
    input  logic [1:0]        sample_addr_wr,
    input  logic              sample_inc,
    input  logic [7:0]        sample_out,
    output logic [7:0]        sample_in,
    output logic              sample_valid,
    output logic [ROM_AW-1:0] rom_addr,
    output logic              rom_req,
    input  logic              rom_ack,
    input  logic [7:0]        rom_data,
    output logic [15:0]       dac_out,
    output logic              dac_strobe,
    output logic              dbg_state_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cur_addr_q, cur_addr_d;
    logic              pending_q, pending_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              rom_req_q, rom_req_d;
    logic [7:0]        sample_in_q, sample_in_d;
    logic              sample_valid_q, sample_valid_d;
    logic [15:0]       dac_out_q, dac_out_d;
    logic              dac_strobe_q, dac_strobe_d;
    logic              addr_change;

    // Byte writes take priority over the increment; the DAC latch is independent.
    always_comb begin
        cur_addr_d = cur_addr_q;
        if (sample_addr_wr[0]) cur_addr_d[7:0]  = sample_addr[7:0];
        if (sample_addr_wr[1]) cur_addr_d[15:8] = sample_addr[15:8];
        if ((sample_addr_wr == 2'b00) && sample_inc) cur_addr_d = cur_addr_q + 16'd1;
    end

    assign addr_change = (cur_addr_d != cur_addr_q);

    always_comb begin
        state_d        = state_q;
        pending_d      = pending_q | addr_change;
        rom_addr_d     = rom_addr_q;
        rom_req_d      = rom_req_q;
        sample_in_d    = sample_in_q;
        sample_valid_d = sample_valid_q & ~addr_change;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    rom_addr_d = ROM_BASE + ROM_AW'(cur_addr_q);
                    rom_req_d  = 1'b1;
                    pending_d  = addr_change;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (rom_ack) begin
                    rom_req_d = 1'b0;
                    state_d   = ST_IDLE;
                    // Data for a stale address is dropped; IDLE re-issues for the new one.
                    if (!pending_q && !addr_change) begin
                        sample_in_d    = rom_data;
                        sample_valid_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dac_strobe_d = sample_inc;
        dac_out_d    = dac_out_q;
        if (sample_inc) dac_out_d = {sample_out ^ 8'h80, 8'h00};
    end

    always_ff @(posedge CLK_32M or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            cur_addr_q     <= 16'h0000;
            pending_q      <= 1'b1;
            rom_addr_q     <= ROM_BASE;
            rom_req_q      <= 1'b0;
            sample_in_q    <= 8'h00;
            sample_valid_q <= 1'b0;
            dac_out_q      <= 16'h0000;
            dac_strobe_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            cur_addr_q     <= cur_addr_d;
            pending_q      <= pending_d;
            rom_addr_q     <= rom_addr_d;
            rom_req_q      <= rom_req_d;
            sample_in_q    <= sample_in_d;
            sample_valid_q <= sample_valid_d;
            dac_out_q      <= dac_out_d;
            dac_strobe_q   <= dac_strobe_d;
        end
    end

    assign sample_in    = sample_in_q;
    assign sample_valid = sample_valid_q;
    assign rom_addr     = rom_addr_q;
    assign rom_req      = rom_req_q;
    assign dac_out      = dac_out_q;
    assign dac_strobe   = dac_strobe_q;
    assign dbg_state_o  = state_q;

endmodule
